// File: rtl/ltl_monitor_ctrl.sv
// Sequencing controller for one automata monitor cluster: arms the automaton,
// streams trace symbols into it, samples its reports and returns a verdict record.
module ltl_monitor_ctrl #(
    parameter int NUM_REPORTS = 4,
    parameter int SYM_W       = 8,
    parameter int CNT_W       = 16,
    parameter int REPORT_LAT  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   abort,
    input  logic                   sym_valid,
    output logic                   sym_ready,
    input  logic [SYM_W-1:0]       sym_data,
    input  logic                   sym_last,
    output logic                   aut_reset,
    output logic                   aut_run,
    output logic [SYM_W-1:0]       aut_symbols,
    input  logic [NUM_REPORTS-1:0] aut_reports,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [NUM_REPORTS-1:0] res_flags,
    output logic [CNT_W-1:0]       res_first_idx,
    output logic [CNT_W-1:0]       res_count,
    output logic                   busy
);

    typedef enum logic [2:0] {IDLE, ARM, RUN, DRAIN, RESULT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                state, state_nx;
    logic                  accept;
    logic                  kill;
    logic                  start;
    logic                  seen;
    logic [REPORT_LAT-1:0] pipe_vld;
    logic [REPORT_LAT-1:0] pipe_last;
    logic [CNT_W-1:0]      pipe_idx [REPORT_LAT];

    assign sym_ready = (state == ARM) || (state == RUN);
    assign kill      = abort && (state != IDLE);
    assign accept    = sym_ready && sym_valid && !abort;
    assign start     = (state == IDLE) && sym_valid;
    assign busy      = (state != IDLE);
    assign res_valid = (state == RESULT);
    assign aut_reset = reset || (state == ARM);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sym_valid) state_nx = ARM;
            ARM:     state_nx = (accept && sym_last) ? DRAIN : RUN;
            RUN:     if (accept && sym_last) state_nx = DRAIN;
            // Only one last-flagged entry can be in flight, so its arrival at the tap ends the trace.
            DRAIN:   if (pipe_vld[REPORT_LAT-1] && pipe_last[REPORT_LAT-1]) state_nx = RESULT;
            RESULT:  if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (kill) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            aut_run       <= 1'b0;
            aut_symbols   <= '0;
            pipe_vld      <= '0;
            pipe_last     <= '0;
            res_flags     <= '0;
            res_first_idx <= '1;
            res_count     <= '0;
            seen          <= 1'b0;
            for (int unsigned i = 0; i < REPORT_LAT; i++) pipe_idx[i] <= '0;
        end else begin
            state   <= state_nx;
            aut_run <= accept;
            if (accept) aut_symbols <= sym_data;

            if (kill) begin
                pipe_vld  <= '0;
                pipe_last <= '0;
            end else begin
                pipe_vld  <= (pipe_vld << 1) | REPORT_LAT'(accept);
                pipe_last <= (pipe_last << 1) | REPORT_LAT'(accept && sym_last);
            end
            pipe_idx[0] <= res_count;
            for (int unsigned i = 1; i < REPORT_LAT; i++) pipe_idx[i] <= pipe_idx[i-1];

            if (start) begin
                res_count <= '0;
            end else if (accept && (res_count != CNT_MAX)) begin
                res_count <= res_count + CNT_W'(1);
            end

            // Samples without a matching accept are stall cycles and carry no verdict.
            if (start) begin
                res_flags     <= '0;
                res_first_idx <= '1;
                seen          <= 1'b0;
            end else if (pipe_vld[REPORT_LAT-1]) begin
                res_flags <= res_flags | aut_reports;
                if ((aut_reports != '0) && !seen) begin
                    res_first_idx <= pipe_idx[REPORT_LAT-1];
                    seen          <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ltl_monitor_ctrl.sv
// Self-checking bench for ltl_monitor_ctrl: stub automaton with a symbol->report map,
// randomized traces, and a trace-level reference model for the verdict record.
module tb_ltl_monitor_ctrl;

    localparam int NR  = 4;
    localparam int SW  = 8;
    localparam int CW  = 16;
    localparam int CW4 = 4;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          abort = 1'b0;
    logic          sym_valid = 1'b0;
    logic          sym_last = 1'b0;
    logic [SW-1:0] sym_data = '0;
    logic          res_ready = 1'b0;
    logic [NR-1:0] aut_reports;

    logic          sym_ready, aut_reset, aut_run, res_valid, busy;
    logic [SW-1:0] aut_symbols;
    logic [NR-1:0] res_flags;
    logic [CW-1:0] res_first_idx, res_count;

    logic           sym_ready_4, aut_reset_4, aut_run_4, res_valid_4, busy_4;
    logic [SW-1:0]  aut_symbols_4;
    logic [NR-1:0]  res_flags_4;
    logic [CW4-1:0] res_first_idx_4, res_count_4;

    ltl_monitor_ctrl #(.NUM_REPORTS(NR), .SYM_W(SW), .CNT_W(CW), .REPORT_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .abort(abort),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data), .sym_last(sym_last),
        .aut_reset(aut_reset), .aut_run(aut_run), .aut_symbols(aut_symbols), .aut_reports(aut_reports),
        .res_valid(res_valid), .res_ready(res_ready), .res_flags(res_flags),
        .res_first_idx(res_first_idx), .res_count(res_count), .busy(busy)
    );

    ltl_monitor_ctrl #(.NUM_REPORTS(NR), .SYM_W(SW), .CNT_W(CW4), .REPORT_LAT(LAT)) dut4 (
        .clk(clk), .reset(reset), .abort(abort),
        .sym_valid(sym_valid), .sym_ready(sym_ready_4), .sym_data(sym_data), .sym_last(sym_last),
        .aut_reset(aut_reset_4), .aut_run(aut_run_4), .aut_symbols(aut_symbols_4), .aut_reports(aut_reports),
        .res_valid(res_valid_4), .res_ready(res_ready), .res_flags(res_flags_4),
        .res_first_idx(res_first_idx_4), .res_count(res_count_4), .busy(busy_4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Stub automaton: a symbol presented with run in cycle c reports map[symbol] in c+1;
    // every other cycle carries random noise that must never be sampled.
    logic [NR-1:0] rep_map [256];
    logic          prev_run = 1'b0;
    logic [SW-1:0] prev_sym = '0;
    logic [NR-1:0] noise = '0;
    always @(posedge clk) begin
        prev_run <= aut_run;
        prev_sym <= aut_symbols;
        noise    <= NR'($urandom);
    end
    assign aut_reports = prev_run ? rep_map[prev_sym] : noise;

    logic [SW-1:0] trace_q [$];

    // Cycle monitor: a symbol accepted in cycle c must be presented with run in c+1.
    logic          mon_on = 1'b0;
    logic          exp_run = 1'b0;
    logic [SW-1:0] exp_sym = '0;
    logic          prev_arm = 1'b0;
    logic          prev_rv = 1'b0;
    logic          run_seen = 1'b0;
    int arm_cnt = 0, arm_cyc = -1, first_run_cyc = -1, last_acc_cyc = -1, rise_cyc = -1;

    always @(negedge clk) begin
        #2;
        if (mon_on) begin
            checks++;
            if (aut_run !== exp_run) begin
                errors++;
                $display("FAIL aut_run cyc=%0d: got %b expected %b", cyc, aut_run, exp_run);
            end
            if (exp_run) begin
                checks++;
                if (aut_symbols !== exp_sym) begin
                    errors++;
                    $display("FAIL aut_symbols cyc=%0d: got %h expected %h", cyc, aut_symbols, exp_sym);
                end
            end
            if (aut_reset && !reset) begin
                checks++;
                if (prev_arm) begin
                    errors++;
                    $display("FAIL arm_width cyc=%0d: got aut_reset high 2+ cycles expected 1", cyc);
                end
            end
        end
        if (aut_reset && !reset && !prev_arm) begin
            arm_cnt++;
            arm_cyc  = cyc;
            run_seen = 1'b0;
        end
        if (aut_run && !run_seen) begin
            run_seen      = 1'b1;
            first_run_cyc = cyc;
        end
        if (res_valid && !prev_rv) rise_cyc = cyc;
        prev_arm = aut_reset && !reset;
        prev_rv  = res_valid;
        exp_run  = sym_valid && sym_ready && !abort && !reset;
        exp_sym  = sym_data;
        if (exp_run) last_acc_cyc = cyc;
    end

    function automatic void model(input int cw, output logic [NR-1:0] f, output int first, output int cnt);
        int mx;
        mx    = (1 << cw) - 1;
        f     = '0;
        first = -1;
        foreach (trace_q[i]) begin
            if (rep_map[trace_q[i]] != '0 && first < 0) first = (i < mx) ? i : mx;
            f |= rep_map[trace_q[i]];
        end
        if (first < 0) first = mx;
        cnt = (trace_q.size() < mx) ? trace_q.size() : mx;
    endfunction

    task automatic clear_map();
        foreach (rep_map[k]) rep_map[k] = '0;
    endtask

    task automatic put_sym(input logic [SW-1:0] d, input logic last);
        int n = 0;
        sym_valid = 1'b1;
        sym_data  = d;
        sym_last  = last;
        while (sym_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sym_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL sym_ready timeout: got %b expected 1", sym_ready);
        end
        @(negedge clk);
        sym_valid = 1'b0;
        sym_last  = 1'b0;
    endtask

    task automatic send_trace(input int gap_at, input int gap_len, input int max_gap);
        int g;
        foreach (trace_q[i]) begin
            put_sym(trace_q[i], i == trace_q.size() - 1);
            if (i != trace_q.size() - 1) begin
                g = (i == gap_at) ? gap_len : int'($urandom_range(max_gap));
                repeat (g) @(negedge clk);
            end
        end
    endtask

    task automatic check_result(input string name, input int hold, input int arm0, input bit chk4,
                                output logic [NR+2*CW-1:0] got);
        logic [NR-1:0] ef, ef4;
        int efi, ec, efi4, ec4;
        int n = 0;
        got = '0;
        model(CW, ef, efi, ec);
        model(CW4, ef4, efi4, ec4);
        while (res_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s res_valid timeout: got %b expected 1", name, res_valid);
            return;
        end
        #3;
        got = {res_flags, res_first_idx, res_count};
        checks++;
        if (res_flags !== ef) begin
            errors++;
            $display("FAIL %s res_flags: got %b expected %b", name, res_flags, ef);
        end
        checks++;
        if (res_first_idx !== CW'(efi)) begin
            errors++;
            $display("FAIL %s res_first_idx: got %h expected %h", name, res_first_idx, CW'(efi));
        end
        checks++;
        if (res_count !== CW'(ec)) begin
            errors++;
            $display("FAIL %s res_count: got %0d expected %0d", name, res_count, ec);
        end
        checks++;
        if (rise_cyc - last_acc_cyc != LAT + 1) begin
            errors++;
            $display("FAIL %s res_latency: got %0d expected %0d", name, rise_cyc - last_acc_cyc, LAT + 1);
        end
        checks++;
        if (first_run_cyc != arm_cyc + 1 || arm_cnt - arm0 != 1) begin
            errors++;
            $display("FAIL %s arm_pulse: got run-arm=%0d pulses=%0d expected 1 and 1",
                     name, first_run_cyc - arm_cyc, arm_cnt - arm0);
        end
        if (chk4) begin
            checks++;
            if ({res_count_4, res_first_idx_4} !== {CW4'(ec4), CW4'(efi4)}) begin
                errors++;
                $display("FAIL %s cnt4: got count=%0d first=%0d expected count=%0d first=%0d",
                         name, res_count_4, res_first_idx_4, ec4, efi4);
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if ({res_valid, res_flags, res_first_idx, res_count} !== {1'b1, ef, CW'(efi), CW'(ec)}) begin
                errors++;
                $display("FAIL %s hold%0d: got v=%b f=%b i=%h c=%0d expected stable", name, i,
                         res_valid, res_flags, res_first_idx, res_count);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s return_idle: got busy=%b res_valid=%b expected 0 0", name, busy, res_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({sym_ready, aut_run, res_valid, busy, aut_symbols, res_flags, res_count, res_first_idx, aut_reset}
            !== {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 16'h0000, 16'hFFFF, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b run=%b v=%b busy=%b sym=%h f=%b c=%h i=%h ar=%b expected 0 0 0 0 00 0000 0000 ffff 1",
                     sym_ready, aut_run, res_valid, busy, aut_symbols, res_flags, res_count, res_first_idx, aut_reset);
        end
        checks++;
        if ({sym_ready_4, aut_run_4, res_valid_4, busy_4, aut_symbols_4, res_flags_4, res_count_4, res_first_idx_4, aut_reset_4}
            !== {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 4'hF, 1'b1}) begin
            errors++;
            $display("FAIL reset_values4: got c=%h i=%h busy=%b ar=%b expected 0 f 0 1",
                     res_count_4, res_first_idx_4, busy_4, aut_reset_4);
        end
        reset  = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        checks++;
        if (aut_reset !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got aut_reset=%b busy=%b expected 0 0", aut_reset, busy);
        end
    endtask

    task automatic test_basic();
        logic [NR+2*CW-1:0] got;
        int arm0 = arm_cnt;
        clear_map();
        rep_map[8'h50] = 4'b0100;
        trace_q = '{8'h10, 8'h50, 8'hC0};
        send_trace(-1, 0, 0);
        check_result("basic", 0, arm0, 1'b1, got);
    endtask

    task automatic test_single();
        logic [NR+2*CW-1:0] got;
        int arm0 = arm_cnt;
        clear_map();
        rep_map[8'hC0] = 4'b0001;
        trace_q = '{8'hC0};
        send_trace(-1, 0, 0);
        check_result("single", 0, arm0, 1'b1, got);
        checks++;
        if (rise_cyc - arm_cyc != 3) begin
            errors++;
            $display("FAIL single_latency: got %0d expected 3", rise_cyc - arm_cyc);
        end
    endtask

    task automatic test_gaps();
        logic [NR+2*CW-1:0] got_a, got_b;
        int arm0;
        clear_map();
        trace_q.delete();
        for (int i = 0; i < 4; i++) trace_q.push_back(SW'($urandom));
        rep_map[trace_q[2]] = 4'b1000;
        rep_map[trace_q[3]] = NR'($urandom);
        arm0 = arm_cnt;
        send_trace(-1, 0, 0);
        check_result("gapless", 0, arm0, 1'b1, got_a);
        arm0 = arm_cnt;
        send_trace(1, 3, 0);
        check_result("gapped", 0, arm0, 1'b1, got_b);
        checks++;
        if (got_b !== got_a) begin
            errors++;
            $display("FAIL gap_equiv: got %h expected %h", got_b, got_a);
        end
    endtask

    task automatic test_hold();
        logic [NR+2*CW-1:0] got;
        int arm0 = arm_cnt;
        clear_map();
        trace_q.delete();
        for (int i = 0; i < 3; i++) trace_q.push_back(SW'($urandom));
        send_trace(-1, 0, 1);
        check_result("hold", 5, arm0, 1'b1, got);
    endtask

    task automatic test_abort();
        logic [NR+2*CW-1:0] got;
        int arm0;
        clear_map();
        put_sym(8'h11, 1'b0);
        put_sym(8'h22, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (busy !== 1'b0 || res_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle%0d: got busy=%b res_valid=%b expected 0 0", i, busy, res_valid);
            end
            @(negedge clk);
        end
        put_sym(8'h33, 1'b0);
        sym_valid = 1'b1;
        sym_last  = 1'b1;
        sym_data  = 8'h44;
        abort     = 1'b1;
        @(negedge clk);
        {sym_valid, sym_last, abort} = 3'b000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (busy !== 1'b0 || res_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_last%0d: got busy=%b res_valid=%b expected 0 0", i, busy, res_valid);
            end
            @(negedge clk);
        end
        arm0    = arm_cnt;
        trace_q = '{8'h55, 8'h66};
        rep_map[8'h66] = 4'b0010;
        sym_valid = 1'b1;
        sym_data  = trace_q[0];
        abort     = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b1 || aut_reset !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_idle: got busy=%b aut_reset=%b expected 1 1", busy, aut_reset);
        end
        send_trace(-1, 0, 0);
        check_result("after_abort", 0, arm0, 1'b1, got);
    endtask

    task automatic test_saturation();
        logic [NR+2*CW-1:0] got;
        int arm0 = arm_cnt;
        clear_map();
        trace_q.delete();
        for (int i = 0; i < 20; i++) trace_q.push_back(SW'(8'h20 + i));
        rep_map[8'h20 + 17] = 4'b0010;
        send_trace(-1, 0, 0);
        check_result("saturate", 1, arm0, 1'b1, got);
    endtask

    task automatic test_reset_mid_run();
        clear_map();
        rep_map[8'h01] = 4'b1111;
        put_sym(8'h01, 1'b0);
        put_sym(8'h02, 1'b0);
        put_sym(8'h03, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({sym_ready, aut_run, res_valid, busy, aut_symbols, res_flags, res_count, res_first_idx, aut_reset}
            !== {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 16'h0000, 16'hFFFF, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset: got rdy=%b run=%b v=%b busy=%b sym=%h f=%b c=%h i=%h ar=%b expected 0 0 0 0 00 0000 0000 ffff 1",
                     sym_ready, aut_run, res_valid, busy, aut_symbols, res_flags, res_count, res_first_idx, aut_reset);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle: got busy=%b res_valid=%b expected 0 0", busy, res_valid);
        end
    endtask

    task automatic test_random();
        logic [NR+2*CW-1:0] got;
        int arm0;
        for (int t = 0; t < 8; t++) begin
            foreach (rep_map[k]) rep_map[k] = ($urandom_range(3) == 0) ? NR'($urandom) : '0;
            trace_q.delete();
            for (int i = 0; i < int'($urandom_range(9, 1)); i++) trace_q.push_back(SW'($urandom));
            arm0 = arm_cnt;
            send_trace(-1, 0, 2);
            check_result($sformatf("random%0d", t), int'($urandom_range(3)), arm0, 1'b1, got);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_map();
        test_reset();
        test_basic();
        test_single();
        test_gaps();
        test_hold();
        test_abort();
        test_saturation();
        test_reset_mid_run();
        test_random();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/ltl_monitor_ctrl.md
# ltl_monitor_ctrl

Sequencing controller for one homogeneous automata monitor cluster (STE network with `run`/`reset`/`symbols` inputs and one-hot report outputs). It accepts a trace as a valid/ready stream of 8-bit symbols and arms the automaton so the first symbol coincides with the STEs' start-of-data cycle. It feeds symbols with back-pressure, samples the report outputs at a fixed latency, and returns one verdict record per trace over a valid/ready result handshake.

## Interface
- `NUM_REPORTS`, default 4: number of automaton report outputs.
- `SYM_W`, default 8: symbol width.
- `CNT_W`, default 16: width of symbol counter and first-report index.
- `REPORT_LAT`, default 2: cycles from symbol acceptance to that symbol's report sample.
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, synchronous, active-high.
- `abort`, input, 1: discard the current trace; no result is produced.
- `sym_valid`, input, 1: trace symbol valid.
- `sym_ready`, output, 1: controller accepts `sym_data`.
- `sym_data`, input, `SYM_W`: trace symbol.
- `sym_last`, input, 1: last symbol of the trace.
- `aut_reset`, output, 1: automaton reset.
- `aut_run`, output, 1: automaton advance enable.
- `aut_symbols`, output, `SYM_W`: symbol presented to the automaton.
- `aut_reports`, input, `NUM_REPORTS`: automaton report outputs.
- `res_valid`, output, 1: verdict available.
- `res_ready`, input, 1: verdict consumed.
- `res_flags`, output, `NUM_REPORTS`: sticky OR of all report samples in the trace.
- `res_first_idx`, output, `CNT_W`: index of the first symbol that produced any report; all-ones if none.
- `res_count`, output, `CNT_W`: symbols accepted in the trace, saturating.
- `busy`, output, 1: state is not IDLE.

## Operation
- States: IDLE, ARM, RUN, DRAIN, RESULT.
- IDLE: `sym_ready`=0. When `sym_valid`=1, go to ARM and clear the flags, count, and first index.
- ARM (exactly 1 cycle): `aut_reset`=1, `sym_ready`=1. The first symbol is always accepted here because `sym_valid` is held per the handshake rule.
  - If the accepted symbol has `sym_last`=1, go to DRAIN; otherwise go to RUN.
- RUN: `sym_ready`=1. On each accept, register `aut_symbols`<=`sym_data` and `aut_run`<=1. In any cycle with no accept, `aut_run`<=0 and `aut_symbols` is held. Accepting a symbol with `sym_last`=1 goes to DRAIN.
- DRAIN: `sym_ready`=0. Stay until the last accepted symbol's report sample has been taken (`REPORT_LAT` cycles after its acceptance), then go to RESULT.
- RESULT: `res_valid`=1 and the result fields are stable. `res_valid`&&`res_ready` returns to IDLE.
- Report sampling: a `REPORT_LAT`-deep shift pipeline carries {accepted, index}. When the delayed accepted bit is 1:
  - `res_flags` |= `aut_reports`.
  - If `aut_reports`!=0 and no report has been seen yet in this trace, `res_first_idx` <= the delayed index.
  - Samples taken when the delayed accepted bit is 0 (stall cycles) are ignored.
- Index and count: the first symbol has index 0. Both saturate at 2^`CNT_W`-1 and never wrap.
- `abort`=1 in any state other than IDLE: go to IDLE next cycle and clear the pipeline. `aut_run`<=0. No `res_valid`. `abort` in IDLE is ignored.
- `aut_reset` = `reset` OR (state==ARM).

## Timing
- Reset values:
  - `sym_ready`, `aut_run`, `res_valid`, `busy` = 0.
  - `aut_symbols`, `res_flags`, `res_count` = 0.
  - `res_first_idx` = all-ones.
  - `aut_reset` = 1 while `reset` is high.
- `reset` mid-trace behaves like `abort` and additionally clears every register.
- Cycle t: IDLE sees `sym_valid`.
- Cycle t+1: ARM. `aut_reset`=1 and the first symbol is accepted.
- Cycle t+2: `aut_reset`=0, `aut_run`=1, `aut_symbols`=first symbol. This is the automaton's start-of-data cycle.
- A symbol accepted in cycle k is presented to the automaton in k+1. Its report is sampled in cycle k+`REPORT_LAT`.
- Last symbol accepted in cycle k: `res_valid` rises in cycle k+`REPORT_LAT`+1.
- Minimum trace turnaround: a new trace's ARM cycle can occur no earlier than the cycle after the RESULT handshake.
- `sym_ready` depends only on state, never combinationally on `sym_valid`.
- `abort` and `sym_last` accepted in the same cycle: `abort` wins.

## Test plan
- Trace {0x10, 0x50, 0xC0, last}; stub automaton raises report[2] for the sample of index 1 → `res_flags`=4'b0100, `res_first_idx`=1, `res_count`=3. `aut_reset` is high exactly 1 cycle before the first `aut_run`.
- Single-symbol trace 0xC0 with `sym_last`=1; stub raises report[0] → `res_valid` appears 3 cycles after the ARM cycle, with `res_flags`=4'b0001, `res_first_idx`=0, `res_count`=1.
- 4-symbol trace with `sym_valid` deasserted for 3 cycles between symbols 1 and 2 → `aut_run`=0 during the gaps. Reports asserted during gaps are ignored. The result equals that of the gapless run.
- Trace with no reports; `res_ready` held low for 5 cycles → `res_valid` and fields are stable throughout, `res_first_idx`=16'hFFFF. Returns to IDLE on the cycle after `res_ready`.
- `abort` asserted mid-trace after 2 symbols, then a new 2-symbol trace → no result for the aborted trace. The new trace reports `res_count`=2 and a fresh ARM pulse.
- `CNT_W`=4 with a 20-symbol trace → `res_count`=15 (saturated). `reset` asserted in RUN → all outputs return to their reset values the next cycle.
